// File: rtl/ex_hazard_controller_pkg.sv
// ex_hazard_controller_pkg
//   Shared encodings for the execute-stage hazard controller: operand
//   select codes for the two EX operand muxes, the bubble defaults the
//   select registers load when EX receives no instruction, and the
//   sequencing FSM states.
//   Optional feature macro used by the top level: HAZARD_STATS_EN.
package ex_hazard_controller_pkg;

    // Operand-1 mux select codes
    localparam logic [1:0] SEL1_PC   = 2'd0;
    localparam logic [1:0] SEL1_A    = 2'd1;
    localparam logic [1:0] SEL1_FWD  = 2'd2;
    localparam logic [1:0] SEL1_ZERO = 2'd3;

    // Operand-2 mux select codes
    localparam logic [1:0] SEL2_B    = 2'd0;
    localparam logic [1:0] SEL2_TWO  = 2'd1;
    localparam logic [1:0] SEL2_IMM  = 2'd2;
    localparam logic [1:0] SEL2_FWD  = 2'd3;

    // Select values loaded when a bubble enters EX
    localparam logic [1:0] SEL1_BUBBLE = SEL1_A;
    localparam logic [1:0] SEL2_BUBBLE = SEL2_B;

    // Stall cycles needed for a load-use hazard (load in EX) and for a
    // distance-2 producer (in MEM)
    localparam logic [1:0] NEED_NONE = 2'd0;
    localparam logic [1:0] NEED_MEM  = 2'd1;
    localparam logic [1:0] NEED_LOAD = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/ex_hazard_controller_hazard_match.sv
// hazard_match
//   Combinational compare of one in-flight destination record against the
//   two source operands of the instruction in ID. Register 0 never matches.
//   Ports:
//     i_rec_valid, i_rec_rd, i_rec_regwrite : in-flight record fields
//     i_rs1/i_use_rs1, i_rs2/i_use_rs2      : ID source addresses and uses
//     o_match1, o_match2                    : per-source match flags
module hazard_match
    import ex_hazard_controller_pkg::*;
#(
    parameter int unsigned REG_AW = 4
) (
    input  logic              i_rec_valid,
    input  logic [REG_AW-1:0] i_rec_rd,
    input  logic              i_rec_regwrite,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic              i_use_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic              i_use_rs2,
    output logic              o_match1,
    output logic              o_match2
);

    logic w_rec_live;

    always_comb begin
        w_rec_live = i_rec_valid && i_rec_regwrite;
        o_match1   = w_rec_live && i_use_rs1 && (i_rs1 != '0) && (i_rec_rd == i_rs1);
        o_match2   = w_rec_live && i_use_rs2 && (i_rs2 != '0) && (i_rec_rd == i_rs2);
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// ex_hazard_controller
//   Execute-stage sequencer for the 16-bit 5-stage pipeline. Tracks the
//   destinations of the instructions in EX and MEM, produces registered
//   operand-select codes for the EX muxes (with EX->EX forwarding of a
//   non-load result), stalls IF/ID with bubble injection on hazards that
//   forwarding cannot cover, and flushes younger instructions on a taken
//   branch.
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     id_*                         : decoded fields of the instruction in ID
//     ex_branch_taken              : branch resolved taken in EX
//     aluin1_sel, aluin2_sel       : registered EX operand selects
//     stall, flush_if_id,
//     flush_id_ex                  : combinational pipeline controls
//   Optional feature: define HAZARD_STATS_EN to add saturating counters
//     stall_cycles[15:0] and flush_events[15:0].
module ex_hazard_controller
    import ex_hazard_controller_pkg::*;
#(
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [1:0]        id_src1,
    input  logic [1:0]        id_src2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_branch_taken,
    output logic [1:0]        aluin1_sel,
    output logic [1:0]        aluin2_sel,
    output logic              stall,
    output logic              flush_if_id,
`ifdef HAZARD_STATS_EN
    output logic [15:0]       stall_cycles,
    output logic [15:0]       flush_events,
`endif
    output logic              flush_id_ex
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } ex_rec_t;

    // The load flag is only consulted while the producer sits in EX, so
    // the MEM copy does not carry it.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } mem_rec_t;

    ex_rec_t          r_ex_rec;
    mem_rec_t         r_mem_rec;
    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic [1:0]       r_aluin1_sel;
    logic [1:0]       r_aluin2_sel;

    logic       w_ex_m1;
    logic       w_ex_m2;
    logic       w_mem_m1;
    logic       w_mem_m2;
    logic [1:0] w_need;
    logic       w_fwd1;
    logic       w_fwd2;
    logic [1:0] w_sel1_nxt;
    logic [1:0] w_sel2_nxt;
    logic       w_bubble;

    hazard_match #(.REG_AW(REG_AW)) u_match_ex (
        .i_rec_valid    (r_ex_rec.valid),
        .i_rec_rd       (r_ex_rec.rd),
        .i_rec_regwrite (r_ex_rec.regwrite),
        .i_rs1          (id_rs1),
        .i_use_rs1      (id_use_rs1),
        .i_rs2          (id_rs2),
        .i_use_rs2      (id_use_rs2),
        .o_match1       (w_ex_m1),
        .o_match2       (w_ex_m2)
    );

    hazard_match #(.REG_AW(REG_AW)) u_match_mem (
        .i_rec_valid    (r_mem_rec.valid),
        .i_rec_rd       (r_mem_rec.rd),
        .i_rec_regwrite (r_mem_rec.regwrite),
        .i_rs1          (id_rs1),
        .i_use_rs1      (id_use_rs1),
        .i_rs2          (id_rs2),
        .i_use_rs2      (id_use_rs2),
        .o_match1       (w_mem_m1),
        .o_match2       (w_mem_m2)
    );

    // Stall requirement and forwarding decisions for the instruction in ID
    always_comb begin
        w_need = NEED_NONE;
        if (id_valid) begin
            if ((w_ex_m1 || w_ex_m2) && r_ex_rec.memread) begin
                w_need = NEED_LOAD;
            end else if (w_mem_m1 || w_mem_m2) begin
                w_need = NEED_MEM;
            end
        end

        // Only a non-load EX producer can be forwarded, and only into the
        // mux input that would otherwise read the register file.
        w_fwd1     = w_ex_m1 && !r_ex_rec.memread && (id_src1 == SEL1_A);
        w_fwd2     = w_ex_m2 && !r_ex_rec.memread && (id_src2 == SEL2_B);
        w_sel1_nxt = w_fwd1 ? SEL1_FWD : id_src1;
        w_sel2_nxt = w_fwd2 ? SEL2_FWD : id_src2;
        w_bubble   = flush_id_ex || !id_valid;
    end

    // Sequencing FSM: next state and pipeline controls
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        stall           = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;

        if (ex_branch_taken) begin
            // A taken branch discards the ID instruction, so any stall
            // in progress is abandoned.
            flush_if_id     = 1'b1;
            flush_id_ex     = 1'b1;
            w_state_nxt     = ST_RUN;
            w_stall_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (w_need != NEED_NONE) begin
                        stall           = 1'b1;
                        flush_id_ex     = 1'b1;
                        w_stall_cnt_nxt = CNT_W'(w_need - 2'd1);
                        w_state_nxt     = ((w_need - 2'd1) != 2'd0) ? ST_STALL : ST_RUN;
                    end
                end
                ST_STALL: begin
                    stall       = 1'b1;
                    flush_id_ex = 1'b1;
                    if (r_stall_cnt <= CNT_W'(1)) begin
                        w_stall_cnt_nxt = '0;
                        w_state_nxt     = ST_RUN;
                    end else begin
                        w_stall_cnt_nxt = r_stall_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt     = ST_RUN;
                    w_stall_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    // In-flight destination records
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_rec  <= '0;
            r_mem_rec <= '0;
        end else begin
            r_mem_rec.valid    <= r_ex_rec.valid;
            r_mem_rec.rd       <= r_ex_rec.rd;
            r_mem_rec.regwrite <= r_ex_rec.regwrite;
            if (flush_id_ex) begin
                r_ex_rec <= '0;
            end else begin
                r_ex_rec.valid    <= id_valid;
                r_ex_rec.rd       <= id_rd;
                r_ex_rec.regwrite <= id_regwrite;
                r_ex_rec.memread  <= id_memread;
            end
        end
    end

    // Registered EX operand selects
    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_aluin1_sel <= SEL1_BUBBLE;
            r_aluin2_sel <= SEL2_BUBBLE;
        end else begin
            r_aluin1_sel <= w_sel1_nxt;
            r_aluin2_sel <= w_sel2_nxt;
        end
    end

    assign aluin1_sel = r_aluin1_sel;
    assign aluin2_sel = r_aluin2_sel;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            if (ex_branch_taken && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 16'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_ex_hazard_controller.sv
module tb_ex_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [1:0] id_src1;
    logic [1:0] id_src2;
    logic [3:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_branch_taken;
    logic [1:0] aluin1_sel;
    logic [1:0] aluin2_sel;
    logic       stall;
    logic       flush_if_id;
    logic       flush_id_ex;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_hazard_controller #(.REG_AW(4), .CNT_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .aluin1_sel      (aluin1_sel),
        .aluin2_sel      (aluin2_sel),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
`ifdef HAZARD_STATS_EN
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
`endif
        .flush_id_ex     (flush_id_ex)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [3:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_src1 = s1; id_src2 = s2; id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic clear_id();
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        clear_id();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++; if (aluin1_sel !== 2'd1) begin miscompares++; $display("FAIL rst_sel1: got %0d want 1", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd0) begin miscompares++; $display("FAIL rst_sel2: got %0d want 0", aluin2_sel); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %0b want 0", stall); end
        vectors++; if (flush_if_id !== 1'b0) begin miscompares++; $display("FAIL rst_fifid: got %0b want 0", flush_if_id); end
        vectors++; if (flush_id_ex !== 1'b0) begin miscompares++; $display("FAIL rst_fidex: got %0b want 0", flush_id_ex); end
`ifdef HAZARD_STATS_EN
        vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL rst_scyc: got %0d want 0", stall_cycles); end
`endif
    endtask

    // ADD r3,r1,r2 ; SUB r4,r3,r5 ; ADD r8,r9,r4 ; ADDI r10,r8,imm
    task automatic test_back_to_back();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 2'd1, 2'd0, 4'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 2'd1, 2'd0, 4'd4, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall: got %0b want 0", stall); end
        vectors++; if (flush_id_ex !== 1'b0) begin miscompares++; $display("FAIL b2b_fidex: got %0b want 0", flush_id_ex); end
        tick();
        vectors++; if (aluin1_sel !== 2'd2) begin miscompares++; $display("FAIL b2b_sub_sel1: got %0d want 2", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd0) begin miscompares++; $display("FAIL b2b_sub_sel2: got %0d want 0", aluin2_sel); end
        set_id(1'b1, 4'd9, 1'b1, 4'd4, 1'b1, 2'd1, 2'd0, 4'd8, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall2: got %0b want 0", stall); end
        tick();
        vectors++; if (aluin1_sel !== 2'd1) begin miscompares++; $display("FAIL b2b_rs2_sel1: got %0d want 1", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd3) begin miscompares++; $display("FAIL b2b_rs2_sel2: got %0d want 3", aluin2_sel); end
        // rs2 matches but operand 2 is the immediate: no forward code
        set_id(1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 2'd3, 2'd2, 4'd10, 1'b1, 1'b0);
        tick();
        vectors++; if (aluin1_sel !== 2'd3) begin miscompares++; $display("FAIL b2b_imm_sel1: got %0d want 3", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd2) begin miscompares++; $display("FAIL b2b_imm_sel2: got %0d want 2", aluin2_sel); end
    endtask

    // LOAD r2 ; ADD r6,r1,r2
    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 2'd1, 2'd2, 4'd2, 1'b1, 1'b1);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_load_stall: got %0b want 0", stall); end
        tick();
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 2'd1, 2'd0, 4'd6, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall_c1: got %0b want 1", stall); end
        vectors++; if (flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL lu_fidex_c1: got %0b want 1", flush_id_ex); end
        vectors++; if (flush_if_id !== 1'b0) begin miscompares++; $display("FAIL lu_fifid_c1: got %0b want 0", flush_if_id); end
        tick();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall_c2: got %0b want 1", stall); end
        vectors++; if (flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL lu_fidex_c2: got %0b want 1", flush_id_ex); end
        vectors++; if (aluin2_sel !== 2'd0) begin miscompares++; $display("FAIL lu_bubble_sel2: got %0d want 0", aluin2_sel); end
        tick();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_stall_c3: got %0b want 0", stall); end
        vectors++; if (flush_id_ex !== 1'b0) begin miscompares++; $display("FAIL lu_fidex_c3: got %0b want 0", flush_id_ex); end
        tick();
        vectors++; if (aluin1_sel !== 2'd1) begin miscompares++; $display("FAIL lu_add_sel1: got %0d want 1", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd0) begin miscompares++; $display("FAIL lu_add_sel2: got %0d want 0", aluin2_sel); end
`ifdef HAZARD_STATS_EN
        vectors++; if (stall_cycles !== 16'd2) begin miscompares++; $display("FAIL lu_scyc: got %0d want 2", stall_cycles); end
`endif
    endtask

    // ADD r3 ; NOP ; ADD r7,r3,imm
    task automatic test_distance2();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 2'd1, 2'd0, 4'd3, 1'b1, 1'b0);
        tick();
        clear_id();
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL d2_nop_stall: got %0b want 0", stall); end
        tick();
        set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 2'd1, 2'd2, 4'd7, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL d2_stall_c1: got %0b want 1", stall); end
        vectors++; if (flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL d2_fidex_c1: got %0b want 1", flush_id_ex); end
        tick();
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL d2_stall_c2: got %0b want 0", stall); end
        tick();
        vectors++; if (aluin1_sel !== 2'd1) begin miscompares++; $display("FAIL d2_sel1: got %0d want 1", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd2) begin miscompares++; $display("FAIL d2_sel2: got %0d want 2", aluin2_sel); end
    endtask

    // LOAD r0 in EX, consumer reads r0; then an invalid ID slot aliasing a load dest
    task automatic test_reg_zero();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 2'd1, 2'd2, 4'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 2'd1, 2'd0, 4'd5, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL r0_stall: got %0b want 0", stall); end
        tick();
        vectors++; if (aluin1_sel !== 2'd1) begin miscompares++; $display("FAIL r0_sel1: got %0d want 1", aluin1_sel); end
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 2'd1, 2'd2, 4'd9, 1'b1, 1'b1);
        tick();
        set_id(1'b0, 4'd9, 1'b1, 4'd9, 1'b1, 2'd1, 2'd0, 4'd4, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL inv_stall: got %0b want 0", stall); end
    endtask

    // Load-use stall, branch taken in the second stall cycle
    task automatic test_branch_override();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 2'd1, 2'd2, 4'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 2'd1, 2'd0, 4'd6, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL br_stall_c1: got %0b want 1", stall); end
        tick();
        ex_branch_taken = 1'b1;
        #1;
        vectors++; if (flush_if_id !== 1'b1) begin miscompares++; $display("FAIL br_fifid: got %0b want 1", flush_if_id); end
        vectors++; if (flush_id_ex !== 1'b1) begin miscompares++; $display("FAIL br_fidex: got %0b want 1", flush_id_ex); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL br_stall: got %0b want 0", stall); end
        tick();
        ex_branch_taken = 1'b0;
        set_id(1'b1, 4'd10, 1'b1, 4'd11, 1'b1, 2'd1, 2'd0, 4'd9, 1'b1, 1'b0);
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL br_run_stall: got %0b want 0", stall); end
        vectors++; if (flush_id_ex !== 1'b0) begin miscompares++; $display("FAIL br_run_fidex: got %0b want 0", flush_id_ex); end
        vectors++; if (flush_if_id !== 1'b0) begin miscompares++; $display("FAIL br_run_fifid: got %0b want 0", flush_if_id); end
`ifdef HAZARD_STATS_EN
        vectors++; if (flush_events !== 16'd1) begin miscompares++; $display("FAIL br_fev: got %0d want 1", flush_events); end
        vectors++; if (stall_cycles !== 16'd1) begin miscompares++; $display("FAIL br_scyc: got %0d want 1", stall_cycles); end
`endif
    endtask

    // Reset asserted while in STALL
    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 2'd1, 2'd2, 4'd2, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 2'd1, 2'd0, 4'd6, 1'b1, 1'b0);
        tick();
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rms_pre_stall: got %0b want 1", stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rms_stall: got %0b want 0", stall); end
        vectors++; if (flush_id_ex !== 1'b0) begin miscompares++; $display("FAIL rms_fidex: got %0b want 0", flush_id_ex); end
        vectors++; if (flush_if_id !== 1'b0) begin miscompares++; $display("FAIL rms_fifid: got %0b want 0", flush_if_id); end
        vectors++; if (aluin1_sel !== 2'd1) begin miscompares++; $display("FAIL rms_sel1: got %0d want 1", aluin1_sel); end
        vectors++; if (aluin2_sel !== 2'd0) begin miscompares++; $display("FAIL rms_sel2: got %0d want 0", aluin2_sel); end
`ifdef HAZARD_STATS_EN
        vectors++; if (stall_cycles !== 16'd0) begin miscompares++; $display("FAIL rms_scyc: got %0d want 0", stall_cycles); end
        vectors++; if (flush_events !== 16'd0) begin miscompares++; $display("FAIL rms_fev: got %0d want 0", flush_events); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        clear_id();
        test_reset();
        test_back_to_back();
        test_load_use();
        test_distance2();
        test_reg_zero();
        test_branch_override();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
